// File: rtl/pattern_loader_if.sv
// Host-side byte streams of the pattern loader: bytes to load in, read-back bytes out.
interface pattern_loader_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pattern_loader.sv
// Serial scan master for the pattern buffer: frames one full load or rotate/readback,
// one host byte per entry, entry BUFFER_SIZE-1 first, MSB first.
module pattern_loader #(
    parameter int BUFFER_WIDTH = 8,
    parameter int BUFFER_SIZE  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rotate,
    pattern_loader_if.slave   host,
    output logic              busy,
    output logic              done,
    output logic              buf_ssel,
    output logic              buf_sin,
    input  logic              buf_sout
);
    localparam int BIT_CW  = $clog2(BUFFER_WIDTH);
    localparam int BYTE_CW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(BUFFER_WIDTH - 1);
    localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(BUFFER_SIZE - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, PUSH, DONE} state_t;

    state_t                  state, state_n;
    logic                    rot;
    logic [BYTE_CW-1:0]      byte_cnt;
    logic [BIT_CW-1:0]       bit_cnt;
    logic [BUFFER_WIDTH-1:0] tx_shift;
    logic [BUFFER_WIDTH-1:0] rx_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rot      <= 1'b0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    rot      <= rotate;
                    byte_cnt <= '0;
                end
                FETCH: begin
                    bit_cnt <= '0;
                    if (!rot && host.in_valid) tx_shift <= host.in_data;
                end
                SHIFT: begin
                    // sout is sampled at the same edge the buffer shifts, so the
                    // first captured bit is the buffer's original top MSB.
                    rx_shift <= {rx_shift[BUFFER_WIDTH-2:0], buf_sout};
                    tx_shift <= tx_shift << 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                PUSH: if (host.out_ready) byte_cnt <= byte_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n        = state;
        host.in_ready  = 1'b0;
        host.out_valid = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        buf_ssel       = 1'b0;
        buf_sin        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = FETCH;
            end
            FETCH: begin
                host.in_ready = !rot;
                if (rot || host.in_valid) state_n = SHIFT;
            end
            SHIFT: begin
                // ssel only here: host stalls in FETCH/PUSH never move the buffer
                buf_ssel = 1'b1;
                buf_sin  = rot ? buf_sout : tx_shift[BUFFER_WIDTH-1];
                if (bit_cnt == BIT_LAST) state_n = PUSH;
            end
            PUSH: begin
                host.out_valid = 1'b1;
                if (host.out_ready) state_n = (byte_cnt == BYTE_LAST) ? DONE : FETCH;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign host.out_data = rx_shift;
endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Host-side serial master for the pattern buffer's scan interface. Frames one full load or readback of the buffer.
- Takes bytes from the host over a valid/ready stream and shifts them serially into the buffer on sin, with ssel asserted.
- Captures the bits the buffer returns on sout into bytes and hands them back over a second valid/ready stream.
- Rotate mode feeds sout back into sin, giving a non-destructive readback that leaves buffer contents unchanged.

Parameters:
- BUFFER_WIDTH, 8: bits per buffer entry; one host byte per entry.
- BUFFER_SIZE, 32: entries per frame; one frame is BUFFER_WIDTH*BUFFER_SIZE shifts.

Ports:
- clk, input, 1: sole clock. Also drives the pattern buffer's clk.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle frame request. Sampled only in IDLE.
- rotate, input, 1: mode, latched with start. 0 = load; 1 = rotate/readback.
- in_data, input, BUFFER_WIDTH: host byte to load.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: loader accepts in_data.
- out_data, output, BUFFER_WIDTH: byte read back from the buffer.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: host accepts out_data.
- busy, output, 1: frame in progress.
- done, output, 1: one-cycle pulse at frame end.
- buf_ssel, output, 1: to buffer ssel.
- buf_sin, output, 1: to buffer sin.
- buf_sout, input, 1: from buffer sout (entry BUFFER_SIZE-1, bit BUFFER_WIDTH-1).

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, buf_ssel=0, buf_sin=0. State=IDLE; all counters and shift registers cleared.
- Bit ordering:
  - The first bit shifted lands at entry BUFFER_SIZE-1, bit MSB.
  - The host sends entry BUFFER_SIZE-1 first and entry 0 last, each MSB first.
  - Readback bytes return in the same order (entry BUFFER_SIZE-1 first).
- IDLE:
  - busy=0.
  - On start=1: latch rotate, byte_cnt<=0, go to FETCH.
- FETCH:
  - busy=1.
  - Load mode: in_ready=1. On in_valid&in_ready, tx_shift<=in_data, bit_cnt<=0, go to SHIFT. Otherwise hold, with buf_ssel=0.
  - Rotate mode: in_ready=0. Go to SHIFT the next cycle (bit_cnt<=0).
- SHIFT:
  - buf_ssel=1 throughout.
  - buf_sin: load mode = tx_shift[MSB]; rotate mode = buf_sout (the only combinational input-to-output path).
  - Each cycle: rx_shift<={rx_shift[W-2:0], buf_sout}; tx_shift<<=1; bit_cnt++.
  - When bit_cnt==BUFFER_WIDTH-1: go to PUSH after that edge.
  - buf_sout is sampled before the same edge at which the buffer shifts. The first sampled bit is therefore the buffer's original MSB of entry BUFFER_SIZE-1.
- PUSH:
  - buf_ssel=0, so the buffer holds.
  - out_valid=1; out_data=rx_shift, stable until accepted.
  - On out_ready: byte_cnt++. If byte_cnt==BUFFER_SIZE-1, go to DONE; otherwise go to FETCH.
  - out_valid must not drop without a handshake.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Throughput and latency:
  - Minimum 10 cycles per byte (FETCH 1 + SHIFT 8 + PUSH 1).
  - With in_valid and out_ready held high and start sampled at edge 0, done is high in the cycle after edge 320.
- Stall rules:
  - buf_ssel is high only in SHIFT, so host back-pressure never shifts the buffer.
  - No partial bytes: SHIFT always completes its 8 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - Changes to rotate mid-frame: ignored.
  - Out readback is always produced, including in load mode, where it returns the previous buffer contents.
  - reset mid-frame: next cycle returns to IDLE with all outputs at reset values. The buffer is left partially shifted; there is no restore.
- Field writes on the buffer are the owner's responsibility to suppress while busy=1.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; start pulse while reset=1 is ignored.
- Load mode, host sends 0x1F,0x1E,…,0x00 with in_valid and out_ready always 1 -> buffer model holds pattern[i]=i; done in cycle after edge 320; buf_ssel high exactly 256 cycles.
- Rotate mode after that load -> out_data sequence 0x1F…0x00; pattern[i]=i unchanged; in_ready never asserted.
- Load mode with in_valid gaps (3 idle cycles before every 4th byte) and out_ready low for 5 cycles on byte 7 -> buf_ssel low during every stall; out_data held stable; final contents still correct.
- start pulsed again at byte 10 of a frame -> ignored; exactly one done pulse per frame.
- reset asserted in SHIFT of byte 5 -> next cycle busy=0, buf_ssel=0, out_valid=0; a fresh load frame then completes correctly.
